// File: rtl/banco_fifos_salida_pkg.sv
// Shared FIFO definitions for the output-side FIFO bank and its fifo_simple instances.
// Optional error flags in the FIFOs are enabled with the FIFO_ERR_EN macro.
package banco_fifos_salida_pkg;

    localparam int NUM_FIFOS  = 4;
    localparam int DEST_W     = 2;
    localparam int DEF_DATA_W = 6;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_AF_TH  = 3;

endpackage

// File: rtl/banco_fifos_salida_fifo_simple.sv
// fifo_simple: single-clock FIFO with registered read port, count-based flags and,
// when FIFO_ERR_EN is defined, sticky overflow/underflow error bits.
module fifo_simple
    import banco_fifos_salida_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int AF_TH  = DEF_AF_TH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              almost_full,
    output logic              full
`ifdef FIFO_ERR_EN
    ,
    output logic              err_over,
    output logic              err_under
`endif
);

    localparam int             DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              do_wr;
    logic              do_rd;

    assign empty       = (count == '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= AF_C);

    // A full FIFO still accepts a write when a read frees the slot in the same cycle;
    // an empty FIFO never reads through the word being written.
    assign do_rd = pop && !empty;
    assign do_wr = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_wr && !reset) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_over  <= 1'b0;
            err_under <= 1'b0;
        end else begin
            if (push && full && !pop) begin
                err_over <= 1'b1;
            end
            if (pop && empty) begin
                err_under <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/banco_fifos_salida.sv
// banco_fifos_salida: four independent output FIFOs fed by the arbiter's Push/data_in bus.
// Defining FIFO_ERR_EN adds the sticky err_over/err_under ports.
module banco_fifos_salida
    import banco_fifos_salida_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int AF_TH  = DEF_AF_TH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_FIFOS-1:0]        Push,
    input  logic [DATA_W-1:0]           data_in,
    input  logic [NUM_FIFOS-1:0]        Pop,
    output logic [NUM_FIFOS*DATA_W-1:0] data_out,
    output logic [NUM_FIFOS-1:0]        FIFO_empty,
    output logic [NUM_FIFOS-1:0]        Almost_full,
    output logic [NUM_FIFOS-1:0]        FIFO_full
`ifdef FIFO_ERR_EN
    ,
    output logic [NUM_FIFOS-1:0]        err_over,
    output logic [NUM_FIFOS-1:0]        err_under
`endif
);

    for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_fifo
        fifo_simple #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .AF_TH  (AF_TH)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .push        (Push[i]),
            .pop         (Pop[i]),
            .data_in     (data_in),
            .data_out    (data_out[i*DATA_W +: DATA_W]),
            .empty       (FIFO_empty[i]),
            .almost_full (Almost_full[i]),
            .full        (FIFO_full[i])
`ifdef FIFO_ERR_EN
            ,
            .err_over    (err_over[i]),
            .err_under   (err_under[i])
`endif
        );
    end

endmodule

// File: tb/tb_banco_fifos_salida.sv
// Scoreboard bench for banco_fifos_salida: queue-based reference model, directed scenarios
// followed by randomized Push/Pop/reset traffic.
module tb_banco_fifos_salida;

    typedef logic [5:0] word_t;

    typedef struct {
        logic [3:0]  empty;
        logic [3:0]  af;
        logic [3:0]  full;
        logic [3:0]  eo;
        logic [3:0]  eu;
        logic [23:0] dout;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  Push = '0;
    logic [3:0]  Pop = '0;
    logic [5:0]  data_in = '0;
    logic [23:0] data_out;
    logic [3:0]  FIFO_empty;
    logic [3:0]  Almost_full;
    logic [3:0]  FIFO_full;
`ifdef FIFO_ERR_EN
    logic [3:0]  err_over;
    logic [3:0]  err_under;
`endif

    banco_fifos_salida dut (
        .clk         (clk),
        .reset       (reset),
        .Push        (Push),
        .data_in     (data_in),
        .Pop         (Pop),
        .data_out    (data_out),
        .FIFO_empty  (FIFO_empty),
        .Almost_full (Almost_full),
        .FIFO_full   (FIFO_full)
`ifdef FIFO_ERR_EN
        ,
        .err_over    (err_over),
        .err_under   (err_under)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    word_t mq     [4][$];
    word_t exp_q  [4][$];
    word_t m_dout [4];
    logic [3:0] m_eo;
    logic [3:0] m_eu;
    snap_t snap_q [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and advance the model to the state after the next edge.
    task automatic cycle(input logic [3:0] pu, input logic [3:0] po, input word_t d,
                         input logic rs);
        snap_t s;
        @(negedge clk);
        Push    = pu;
        Pop     = po;
        data_in = d;
        reset   = rs;
        if (rs) begin
            for (int i = 0; i < 4; i++) begin
                mq[i].delete();
                m_dout[i] = '0;
            end
            m_eo = '0;
            m_eu = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                int    n;
                word_t w;
                n = mq[i].size();
                if (po[i] && n > 0) begin
                    w = mq[i].pop_front();
                    exp_q[i].push_back(w);
                    m_dout[i] = w;
                end
                if (pu[i] && (n < 4 || po[i])) mq[i].push_back(d);
                if (pu[i] && n == 4 && !po[i]) m_eo[i] = 1'b1;
                if (po[i] && n == 0) m_eu[i] = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            s.empty[i] = (mq[i].size() == 0);
            s.af[i]    = (mq[i].size() >= 3);
            s.full[i]  = (mq[i].size() == 4);
        end
        s.eo   = m_eo;
        s.eu   = m_eu;
        s.dout = {m_dout[3], m_dout[2], m_dout[1], m_dout[0]};
        snap_q.push_back(s);
    endtask

    // Monitor: detect accepted reads at the edge, compare half a cycle later.
    logic [3:0] fire = '0;
    logic       armed = 1'b0;

    always @(posedge clk) begin
        fire  = Pop & ~FIFO_empty & {4{~reset}};
        armed = (snap_q.size() > 0);
    end

    always @(negedge clk) begin
        if (armed) begin
            snap_t s;
            s = snap_q.pop_front();
            chk("FIFO_empty", 32'(FIFO_empty), 32'(s.empty));
            chk("Almost_full", 32'(Almost_full), 32'(s.af));
            chk("FIFO_full", 32'(FIFO_full), 32'(s.full));
            chk("data_out_hold", 32'(data_out), 32'(s.dout));
`ifdef FIFO_ERR_EN
            chk("err_over", 32'(err_over), 32'(s.eo));
            chk("err_under", 32'(err_under), 32'(s.eu));
`endif
            for (int i = 0; i < 4; i++) begin
                if (fire[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk("rd_unexpected", 32'(i), 32'hFFFF_FFFF);
                    end else begin
                        word_t w;
                        w = exp_q[i].pop_front();
                        chk("rd_data", 32'(data_out[i*6 +: 6]), 32'(w));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pu;
        logic [3:0] po;
        m_eo = '0;
        m_eu = '0;
        for (int i = 0; i < 4; i++) m_dout[i] = '0;

        // Reset then idle
        cycle(4'h0, 4'h0, 6'h00, 1'b1);
        cycle(4'h0, 4'h0, 6'h00, 1'b1);
        cycle(4'h0, 4'h0, 6'h00, 1'b0);
        cycle(4'h0, 4'h0, 6'h00, 1'b0);

        // FIFO0: three pushes, three pops
        cycle(4'h1, 4'h0, 6'h11, 1'b0);
        cycle(4'h1, 4'h0, 6'h12, 1'b0);
        cycle(4'h1, 4'h0, 6'h13, 1'b0);
        cycle(4'h0, 4'h0, 6'h00, 1'b0);
        repeat (3) cycle(4'h0, 4'h1, 6'h00, 1'b0);
        cycle(4'h0, 4'h0, 6'h00, 1'b0);

        // FIFO2: fill, overflow attempt with 3F, drain
        for (int k = 0; k < 4; k++) cycle(4'h4, 4'h0, word_t'(6'h21 + k), 1'b0);
        cycle(4'h4, 4'h0, 6'h3F, 1'b0);
        repeat (4) cycle(4'h0, 4'h4, 6'h00, 1'b0);
        cycle(4'h0, 4'h0, 6'h00, 1'b0);

        // FIFO1: wrap-around with simultaneous push/pop at count 2
        cycle(4'h2, 4'h0, 6'h30, 1'b0);
        cycle(4'h2, 4'h0, 6'h31, 1'b0);
        for (int k = 0; k < 8; k++) cycle(4'h2, 4'h2, word_t'(6'h32 + k), 1'b0);
        repeat (2) cycle(4'h0, 4'h2, 6'h00, 1'b0);

        // FIFO3: push+pop while empty, then pop, then underflow pop
        cycle(4'h8, 4'h8, 6'h05, 1'b0);
        cycle(4'h0, 4'h0, 6'h00, 1'b0);
        cycle(4'h0, 4'h8, 6'h00, 1'b0);
        cycle(4'h0, 4'h8, 6'h00, 1'b0);

        // Full FIFO with push+pop keeps count at full
        for (int k = 0; k < 4; k++) cycle(4'h1, 4'h0, word_t'(6'h08 + k), 1'b0);
        cycle(4'h1, 4'h1, 6'h2A, 1'b0);
        cycle(4'h0, 4'h0, 6'h00, 1'b0);

        // Reset with all FIFOs half full, then pop everything
        cycle(4'hF, 4'h0, 6'h1A, 1'b1);
        cycle(4'hF, 4'h0, 6'h1B, 1'b0);
        cycle(4'hF, 4'h0, 6'h1C, 1'b0);
        cycle(4'h0, 4'h0, 6'h00, 1'b1);
        cycle(4'h0, 4'hF, 6'h00, 1'b0);
        cycle(4'h0, 4'h0, 6'h00, 1'b0);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            pu = 4'($urandom);
            po = 4'($urandom);
            if (k % 150 < 50) po = po & 4'($urandom);
            else if (k % 150 < 100) pu = pu & 4'($urandom);
            cycle(pu, po, 6'($urandom), ($urandom_range(0, 79) == 0));
        end
        cycle(4'h0, 4'h0, 6'h00, 1'b0);

        @(negedge clk);
        @(negedge clk);
        chk("snap_drained", 32'(snap_q.size()), 32'd0);
        for (int i = 0; i < 4; i++) chk("reads_drained", 32'(exp_q[i].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
